// File: rtl/jtframe_romrq_pkg.sv
// Shared types and limits for the ROM request responder and its return pipeline.
package jtframe_romrq_pkg;

    localparam int DW          = 16;
    localparam int MASKW       = 2;
    localparam int BURST_MIN   = 1;
    localparam int BURST_MAX   = 4;
    localparam int LAT_MIN     = 1;
    localparam int LAT_MAX     = 4;
    localparam int ACK_DLY_MAX = 3;
    localparam int IDXW        = $clog2(BURST_MAX);
    localparam int CNTW        = $clog2(ACK_DLY_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACKW,
        ST_READ,
        ST_DRAIN,
        ST_WRITE
    } state_t;

    // Download masks are active low, memory byte enables active high.
    function automatic logic [MASKW-1:0] mask_to_be(input logic [MASKW-1:0] mask);
        return ~mask;
    endfunction

endpackage

// File: rtl/jtframe_romrq_server_if.sv
// ROM request bus, download write port and backing-memory port bundled together.
interface jtframe_romrq_server_if #(
    parameter int AW = 22
) ();
    import jtframe_romrq_pkg::*;

    logic             downloading;
    logic             sdram_req;
    logic [AW-1:0]    sdram_addr;
    logic             sdram_ack;
    logic             data_dst;
    logic             data_rdy;
    logic [DW-1:0]    data_read;
    logic             prog_we;
    logic [AW-1:0]    prog_addr;
    logic [DW-1:0]    prog_data;
    logic [MASKW-1:0] prog_mask;
    logic             prog_rdy;
    logic [AW-1:0]    mem_addr;
    logic             mem_rd;
    logic             mem_we;
    logic [MASKW-1:0] mem_be;
    logic [DW-1:0]    mem_din;
    logic [DW-1:0]    mem_dout;

    // Server side: answers requests and drives the memory port.
    modport slave (
        input  downloading, sdram_req, sdram_addr, prog_we, prog_addr, prog_data,
               prog_mask, mem_dout,
        output sdram_ack, data_dst, data_rdy, data_read, prog_rdy,
               mem_addr, mem_rd, mem_we, mem_be, mem_din
    );

    // Environment side: requester, downloader and memory model.
    modport master (
        output downloading, sdram_req, sdram_addr, prog_we, prog_addr, prog_data,
               prog_mask, mem_dout,
        input  sdram_ack, data_dst, data_rdy, data_read, prog_rdy,
               mem_addr, mem_rd, mem_we, mem_be, mem_din
    );

endinterface

// File: rtl/jtframe_romrq_pipe.sv
// Tracks in-flight memory reads for MEM_LAT cycles and registers returned words onto data_read.
module jtframe_romrq_pipe
    import jtframe_romrq_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int BURST   = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            rd_i,
    input  logic [IDXW-1:0] idx_i,
    input  logic [DW-1:0]   mem_dout_i,
    output logic [DW-1:0]   data_o,
    output logic            dst_o,
    output logic            rdy_o
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BURST - 1);

    logic [MEM_LAT-1:0] vld_q;
    logic [IDXW-1:0]    idx_q [MEM_LAT];
    logic [DW-1:0]      data_q;
    logic               dst_q;
    logic               rdy_q;
    logic               exit_vld;
    logic [IDXW-1:0]    exit_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_i;
            idx_q[0] <= idx_i;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    // A read issued MEM_LAT cycles ago leaves the tracker exactly when mem_dout holds its word.
    assign exit_vld = vld_q[MEM_LAT-1];
    assign exit_idx = idx_q[MEM_LAT-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            dst_q  <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            dst_q <= exit_vld;
            rdy_q <= exit_vld && (exit_idx == LAST_IDX);
            if (exit_vld) begin
                data_q <= mem_dout_i;
            end
        end
    end

    assign data_o = data_q;
    assign dst_o  = dst_q;
    assign rdy_o  = rdy_q;

endmodule

// File: rtl/jtframe_romrq_server.sv
// Responder for the jtframe_rom request bus: burst reads and download writes on a synchronous memory.
module jtframe_romrq_server
    import jtframe_romrq_pkg::*;
#(
    parameter int AW      = 22,
    parameter int BURST   = 2,
    parameter int MEM_LAT = 2,
    parameter int ACK_DLY = 1
) (
    input  logic clk,
    input  logic rstn,
    jtframe_romrq_server_if.slave bus
);

    generate
        if (BURST < BURST_MIN || BURST > BURST_MAX || MEM_LAT < LAT_MIN ||
            MEM_LAT > LAT_MAX || ACK_DLY < 0 || ACK_DLY > ACK_DLY_MAX) begin : g_bad_param
            $error("jtframe_romrq_server: BURST, MEM_LAT or ACK_DLY out of range");
        end
    endgenerate

    localparam logic [CNTW-1:0] ACK_LAST  = CNTW'(ACK_DLY);
    localparam logic [IDXW-1:0] BEAT_LAST = IDXW'(BURST - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [IDXW-1:0]  beat_q, beat_d;

    logic             ack;
    logic             rd;
    logic             we;
    logic [MASKW-1:0] be;
    logic [AW-1:0]    maddr;
    logic [DW-1:0]    din;
    logic             prog_rdy;
    logic             pipe_rdy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        ack      = 1'b0;
        rd       = 1'b0;
        we       = 1'b0;
        be       = '0;
        maddr    = '0;
        din      = '0;
        prog_rdy = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                beat_d = '0;
                if (bus.prog_we) begin
                    state_d = ST_WRITE;
                end else if (bus.sdram_req && !bus.downloading) begin
                    addr_d  = bus.sdram_addr;
                    state_d = ST_ACKW;
                end
            end
            ST_ACKW: begin
                // A request withdrawn before the ack is simply dropped.
                if (!bus.sdram_req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == ACK_LAST) begin
                    ack     = 1'b1;
                    state_d = ST_READ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READ: begin
                rd     = 1'b1;
                maddr  = addr_q;
                addr_d = addr_q + AW'(1);
                beat_d = beat_q + 1'b1;
                if (beat_q == BEAT_LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                we       = 1'b1;
                be       = mask_to_be(bus.prog_mask);
                maddr    = bus.prog_addr;
                din      = bus.prog_data;
                prog_rdy = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    jtframe_romrq_pipe #(
        .MEM_LAT (MEM_LAT),
        .BURST   (BURST)
    ) u_pipe (
        .clk        (clk),
        .rstn       (rstn),
        .rd_i       (rd),
        .idx_i      (beat_q),
        .mem_dout_i (bus.mem_dout),
        .data_o     (bus.data_read),
        .dst_o      (bus.data_dst),
        .rdy_o      (pipe_rdy)
    );

    assign bus.data_rdy  = pipe_rdy;
    assign bus.sdram_ack = ack;
    assign bus.prog_rdy  = prog_rdy;
    assign bus.mem_rd    = rd;
    assign bus.mem_we    = we;
    assign bus.mem_be    = be;
    assign bus.mem_addr  = maddr;
    assign bus.mem_din   = din;

endmodule

// File: tb/tb_jtframe_romrq_server.sv
// Directed bench for jtframe_romrq_server with a small latency-accurate memory model.
module tb_jtframe_romrq_server;

    localparam int AW      = 22;
    localparam int BURST   = 2;
    localparam int MEM_LAT = 2;
    localparam int ACK_DLY = 1;
    localparam int LOGN    = 64;

    logic clk = 1'b0;
    logic rstn;
    logic preload;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    jtframe_romrq_server_if #(.AW(AW)) bus ();

    jtframe_romrq_server #(
        .AW      (AW),
        .BURST   (BURST),
        .MEM_LAT (MEM_LAT),
        .ACK_DLY (ACK_DLY)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 4K words aliased over the address space, MEM_LAT-cycle read.
    logic [15:0] mem [0:4095];
    logic [15:0] rdp [MEM_LAT];

    always @(posedge clk) begin
        if (preload) begin
            mem[12'h100] <= 16'h1234;
            mem[12'h101] <= 16'hABCD;
            mem[12'h102] <= 16'h5678;
            mem[12'hFFF] <= 16'h7777;
            mem[12'h000] <= 16'h0BAD;
            mem[12'h020] <= 16'hFFFF;
            mem[12'h021] <= 16'h2121;
            mem[12'h200] <= 16'hC0DE;
            mem[12'h201] <= 16'hBEEF;
            mem[12'h300] <= 16'h3003;
            mem[12'h301] <= 16'h3113;
        end else if (bus.mem_we) begin
            if (bus.mem_be[0]) mem[bus.mem_addr[11:0]][7:0]  <= bus.mem_din[7:0];
            if (bus.mem_be[1]) mem[bus.mem_addr[11:0]][15:8] <= bus.mem_din[15:8];
        end
        rdp[0] <= mem[bus.mem_addr[11:0]];
        for (int i = 1; i < MEM_LAT; i++) rdp[i] <= rdp[i-1];
    end
    assign bus.mem_dout = rdp[MEM_LAT-1];

    // Event log sampled mid-cycle.
    int          ack_cnt = 0, ack_cyc = 0, rdy_cnt = 0, rdy_cyc = 0;
    int          prog_cnt = 0, prog_cyc = 0, dst_n = 0, rd_n = 0, we_n = 0;
    int          dst_cyc [LOGN];
    logic [15:0] dst_dat [LOGN];
    logic        dst_rdy [LOGN];
    int          rd_cyc  [LOGN];
    logic [21:0] rd_addr [LOGN];
    logic [1:0]  we_be;
    logic [21:0] we_addr;
    logic [15:0] we_din;

    always @(negedge clk) begin
        if (bus.sdram_ack === 1'b1) begin ack_cnt++; ack_cyc = cyc; end
        if (bus.data_rdy === 1'b1) begin rdy_cnt++; rdy_cyc = cyc; end
        if (bus.prog_rdy === 1'b1) begin prog_cnt++; prog_cyc = cyc; end
        if (bus.data_dst === 1'b1 && dst_n < LOGN) begin
            dst_cyc[dst_n] = cyc;
            dst_dat[dst_n] = bus.data_read;
            dst_rdy[dst_n] = bus.data_rdy;
            dst_n++;
        end
        if (bus.mem_rd === 1'b1 && rd_n < LOGN) begin
            rd_cyc[rd_n]  = cyc;
            rd_addr[rd_n] = bus.mem_addr;
            rd_n++;
        end
        if (bus.mem_we === 1'b1) begin
            we_n++;
            we_be   = bus.mem_be;
            we_addr = bus.mem_addr;
            we_din  = bus.mem_din;
        end
    end

    int t0, a1, td;
    int b_ack, b_rdy, b_dst, b_rd, b_p, b_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_ack = ack_cnt; b_rdy = rdy_cnt; b_dst = dst_n;
        b_rd  = rd_n;    b_p   = prog_cnt; b_we = we_n;
    endtask

    task automatic wait_ack(input int target);
        int n = 0;
        while (ack_cnt < target && n < 100) begin cycle(); n++; end
        chk("ack_wait", ack_cnt, target);
    endtask

    task automatic wait_rdy(input int target);
        int n = 0;
        while (rdy_cnt < target && n < 100) begin cycle(); n++; end
        chk("rdy_wait", rdy_cnt, target);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        snap();
        bus.sdram_addr = a;
        bus.sdram_req  = 1'b1;
        t0 = cyc;
        wait_ack(b_ack + 1);
        bus.sdram_req = 1'b0;
        wait_rdy(b_rdy + 1);
    endtask

    task automatic check_burst(input string tag, input logic [15:0] w0, input logic [15:0] w1);
        chk({tag, "_nwords"}, dst_n - b_dst, 2);
        chk({tag, "_w0"}, dst_dat[b_dst], w0);
        chk({tag, "_w1"}, dst_dat[b_dst+1], w1);
        chk({tag, "_rdy0"}, dst_rdy[b_dst], 0);
        chk({tag, "_rdy1"}, dst_rdy[b_dst+1], 1);
        chk({tag, "_rdycnt"}, rdy_cnt - b_rdy, 1);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ack"}, bus.sdram_ack, 0);
        chk({tag, "_dst"}, bus.data_dst, 0);
        chk({tag, "_rdy"}, bus.data_rdy, 0);
        chk({tag, "_data"}, bus.data_read, 0);
        chk({tag, "_prdy"}, bus.prog_rdy, 0);
        chk({tag, "_mrd"}, bus.mem_rd, 0);
        chk({tag, "_mwe"}, bus.mem_we, 0);
        chk({tag, "_mbe"}, bus.mem_be, 0);
        chk({tag, "_maddr"}, bus.mem_addr, 0);
        chk({tag, "_mdin"}, bus.mem_din, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; preload = 1'b1;
        bus.downloading = 1'b0; bus.sdram_req = 1'b0; bus.sdram_addr = '0;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.prog_mask = 2'b00;
        repeat (3) cycle();
        preload = 1'b0;
        check_quiet("reset");
        rstn = 1'b1;
        cycle();
        $display("step reset: outputs quiet");

        // Plain burst at 0x100: ack +2, reads +3/+4, words +6/+7.
        do_read(22'h100);
        chk("t1_ack_cyc", ack_cyc - t0, 2);
        chk("t1_ack_cnt", ack_cnt - b_ack, 1);
        chk("t1_rd_cyc", rd_cyc[b_rd] - t0, 3);
        chk("t1_rd_a0", rd_addr[b_rd], 22'h100);
        chk("t1_rd_a1", rd_addr[b_rd+1], 22'h101);
        chk("t1_dst0_cyc", dst_cyc[b_dst] - t0, 6);
        chk("t1_dst1_cyc", dst_cyc[b_dst+1] - t0, 7);
        chk("t1_rdy_cyc", rdy_cyc - t0, 7);
        check_burst("t1", 16'h1234, 16'hABCD);
        repeat (3) cycle();
        chk("t1_hold_dst", bus.data_dst, 0);
        chk("t1_hold_data", bus.data_read, 16'hABCD);
        $display("step read 0x100: words %h %h", dst_dat[b_dst], dst_dat[b_dst+1]);

        // Back-to-back: second request waits through DRAIN, accepted right after data_rdy.
        snap();
        bus.sdram_addr = 22'h100; bus.sdram_req = 1'b1; t0 = cyc;
        wait_ack(b_ack + 1);
        a1 = ack_cyc;
        bus.sdram_req = 1'b0;
        cycle();
        bus.sdram_addr = 22'h101; bus.sdram_req = 1'b1;
        wait_ack(b_ack + 2);
        bus.sdram_req = 1'b0;
        wait_rdy(b_rdy + 2);
        chk("b2b_period", ack_cyc - a1, 8);
        chk("b2b_w2", dst_dat[b_dst+2], 16'hABCD);
        chk("b2b_w3", dst_dat[b_dst+3], 16'h5678);
        $display("step back-to-back: ack spacing %0d", ack_cyc - a1);

        // Address wrap at the top of the space.
        do_read(22'h3FFFFF);
        chk("wrap_a0", rd_addr[b_rd], 22'h3FFFFF);
        chk("wrap_a1", rd_addr[b_rd+1], 22'h000000);
        check_burst("wrap", 16'h7777, 16'h0BAD);
        $display("step wrap: second addr %h", rd_addr[b_rd+1]);

        // Download write, lower byte only.
        snap();
        bus.prog_addr = 22'h20; bus.prog_data = 16'h55AA; bus.prog_mask = 2'b10;
        bus.prog_we = 1'b1; t0 = cyc;
        for (int n = 0; n < 20 && prog_cnt == b_p; n++) cycle();
        bus.prog_we = 1'b0;
        chk("wr_prdy_cyc", prog_cyc - t0, 1);
        chk("wr_be", we_be, 2'b01);
        chk("wr_addr", we_addr, 22'h20);
        chk("wr_din", we_din, 16'h55AA);
        repeat (2) cycle();
        chk("wr_prdy_cnt", prog_cnt - b_p, 1);
        $display("step write 0x20: be %b", we_be);

        // Fully masked write: still acknowledged, no bytes enabled.
        snap();
        bus.prog_addr = 22'h21; bus.prog_data = 16'h1111; bus.prog_mask = 2'b11;
        bus.prog_we = 1'b1; t0 = cyc;
        for (int n = 0; n < 20 && prog_cnt == b_p; n++) cycle();
        bus.prog_we = 1'b0;
        chk("wrm_prdy_cyc", prog_cyc - t0, 1);
        chk("wrm_be", we_be, 2'b00);
        do_read(22'h20);
        check_burst("wr_rb", 16'hFFAA, 16'h2121);
        $display("step readback 0x20: words %h %h", dst_dat[b_dst], dst_dat[b_dst+1]);

        // Write and read requested together: write first, read accepted on return to IDLE.
        snap();
        bus.prog_addr = 22'h22; bus.prog_data = 16'h3333; bus.prog_mask = 2'b00;
        bus.sdram_addr = 22'h100;
        bus.prog_we = 1'b1; bus.sdram_req = 1'b1; t0 = cyc;
        for (int n = 0; n < 40 && ack_cnt == b_ack; n++) begin
            cycle();
            if (prog_cnt != b_p) bus.prog_we = 1'b0;
        end
        bus.sdram_req = 1'b0; bus.prog_we = 1'b0;
        wait_rdy(b_rdy + 1);
        chk("both_prdy_cyc", prog_cyc - t0, 1);
        chk("both_ack_cyc", ack_cyc - t0, 4);
        chk("both_rd_cyc", rd_cyc[b_rd] - t0, 5);
        chk("both_prdy_cnt", prog_cnt - b_p, 1);
        check_burst("both", 16'h1234, 16'hABCD);
        $display("step write+read: prog_rdy +%0d ack +%0d", prog_cyc - t0, ack_cyc - t0);

        // Requests refused while downloading; downloading rising mid-burst does not cut it short.
        snap();
        bus.downloading = 1'b1; bus.sdram_addr = 22'h300; bus.sdram_req = 1'b1;
        repeat (50) cycle();
        chk("dl_no_ack", ack_cnt - b_ack, 0);
        chk("dl_no_rd", rd_n - b_rd, 0);
        bus.downloading = 1'b0; td = cyc;
        wait_ack(b_ack + 1);
        bus.sdram_req = 1'b0;
        bus.downloading = 1'b1;
        wait_rdy(b_rdy + 1);
        bus.downloading = 1'b0;
        chk("dl_ack_lat", ack_cyc - td, 2);
        check_burst("dl", 16'h3003, 16'h3113);
        $display("step downloading: ack %0d cycles after release", ack_cyc - td);

        // Reset while the burst drains.
        snap();
        bus.sdram_addr = 22'h200; bus.sdram_req = 1'b1; t0 = cyc;
        wait_ack(b_ack + 1);
        bus.sdram_req = 1'b0;
        repeat (3) cycle();
        chk("pre_rst_dst", bus.data_dst, 1);
        chk("pre_rst_data", bus.data_read, 16'hC0DE);
        rstn = 1'b0;
        #1;
        check_quiet("mid_rst");
        repeat (3) cycle();
        rstn = 1'b1;
        repeat (4) cycle();
        chk("mid_rst_no_rdy", rdy_cnt - b_rdy, 0);
        do_read(22'h200);
        chk("post_rst_ack_cyc", ack_cyc - t0, 2);
        chk("post_rst_dst0_cyc", dst_cyc[b_dst] - t0, 6);
        check_burst("post_rst", 16'hC0DE, 16'hBEEF);
        $display("step reset in DRAIN: recovery words %h %h", dst_dat[b_dst], dst_dat[b_dst+1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
